// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a WIDTH-bit up-counter for +1 mod 2^WIDTH steps.
// Acquires lock after LOCK_CYCLES consecutive good steps, then flags sequence
// faults, keeps a saturating fault count and a rolling good-wrap count, and
// pulses tc on every good all-ones -> 0 wrap while locked.
// Optional feature: define COUNT_SEQ_CHK_RESYNC_EN to make a locked fault fall
// back to acquisition (auto-resync) instead of halting in FAULT.
module count_seq_checker #(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned LOCK_CYCLES = 4,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter int unsigned WRAP_CNT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [WIDTH-1:0]      i_count,
  input  logic                  i_clr_err,
  output logic                  o_locked,
  output logic                  o_tc,
  output logic                  o_err,
  output logic                  o_err_sticky,
  output logic [ERR_CNT_W-1:0]  o_err_cnt,
  output logic [WRAP_CNT_W-1:0] o_wrap_cnt,
  output logic [WIDTH-1:0]      o_expected
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // LOCK_CYCLES is limited to 1..15, so a 4-bit run counter suffices.
  localparam logic [3:0] LOCK_CYC = 4'(LOCK_CYCLES);

  logic [1:0]            r_state;
  logic [WIDTH-1:0]      r_prev;
  logic [3:0]            r_run;
  logic                  r_tc;
  logic                  r_err;
  logic                  r_err_sticky;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [WRAP_CNT_W-1:0] r_wrap_cnt;

  logic [1:0]            w_state_d;
  logic [WIDTH-1:0]      w_prev_d;
  logic [3:0]            w_run_d;
  logic [3:0]            w_run_inc;
  logic                  w_tc_d;
  logic                  w_fault;
  logic [WIDTH-1:0]      w_prev_inc;
  logic                  w_good;
  logic [ERR_CNT_W-1:0]  w_err_cnt_base;
  logic [ERR_CNT_W-1:0]  w_err_cnt_d;
  logic                  w_err_sticky_d;
  logic [WRAP_CNT_W-1:0] w_wrap_cnt_d;

  assign w_prev_inc = r_prev + WIDTH'(1);
  assign w_good     = (i_count == w_prev_inc);
  assign w_run_inc  = r_run + 4'd1;

  // Next-state decode for the acquire/lock FSM and the tracked previous count.
  always_comb begin
    w_state_d = r_state;
    w_prev_d  = r_prev;
    w_run_d   = r_run;
    w_tc_d    = 1'b0;
    w_fault   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          w_prev_d  = i_count;
          w_run_d   = 4'd0;
          w_state_d = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (!i_en) begin
          w_run_d   = 4'd0;
          w_state_d = ST_IDLE;
        end else if (w_good) begin
          w_prev_d = i_count;
          w_run_d  = w_run_inc;
          if (w_run_inc == LOCK_CYC) begin
            w_state_d = ST_LOCK;
          end
        end else begin
          // Not locked yet: a bad step only restarts the run.
          w_prev_d = i_count;
          w_run_d  = 4'd0;
        end
      end
      ST_LOCK: begin
        if (!i_en) begin
          w_run_d   = 4'd0;
          w_state_d = ST_IDLE;
        end else if (w_good) begin
          w_prev_d = i_count;
          w_tc_d   = &r_prev;
        end else begin
          w_fault  = 1'b1;
          w_prev_d = i_count;
`ifdef COUNT_SEQ_CHK_RESYNC_EN
          w_run_d   = 4'd0;
          w_state_d = ST_ACQ;
`else
          w_state_d = ST_FAULT;
`endif
        end
      end
      ST_FAULT: begin
        // prev is frozen here; only clr_err (or reset) gets us out.
        if (i_clr_err) begin
          w_run_d   = 4'd0;
          w_state_d = ST_IDLE;
        end
      end
      default: begin
        w_run_d   = 4'd0;
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // Fault bookkeeping: the clear is applied before a same-cycle fault is counted.
  always_comb begin
    w_err_cnt_base = i_clr_err ? '0 : r_err_cnt;
    w_err_cnt_d    = w_err_cnt_base;
    if (w_fault && !(&w_err_cnt_base)) begin
      w_err_cnt_d = w_err_cnt_base + ERR_CNT_W'(1);
    end
    w_err_sticky_d = w_fault | (r_err_sticky & ~i_clr_err);
    w_wrap_cnt_d   = r_wrap_cnt + WRAP_CNT_W'(w_tc_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_prev       <= '0;
      r_run        <= 4'd0;
      r_tc         <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_wrap_cnt   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_prev       <= w_prev_d;
      r_run        <= w_run_d;
      r_tc         <= w_tc_d;
      r_err        <= w_fault;
      r_err_sticky <= w_err_sticky_d;
      r_err_cnt    <= w_err_cnt_d;
      r_wrap_cnt   <= w_wrap_cnt_d;
    end
  end

  assign o_locked     = (r_state == ST_LOCK);
  assign o_tc         = r_tc;
  assign o_err        = r_err;
  assign o_err_sticky = r_err_sticky;
  assign o_err_cnt    = r_err_cnt;
  assign o_wrap_cnt   = r_wrap_cnt;
  // expected only meaningful while checking; forced to 0 in IDLE/FAULT.
  assign o_expected   = ((r_state == ST_ACQ) || (r_state == ST_LOCK)) ? w_prev_inc : '0;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker (default parameters). Expectations are
// hand-derived; the resync branches apply when COUNT_SEQ_CHK_RESYNC_EN is set.
module tb_count_seq_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] count;
  logic       clr_err;
  logic       locked;
  logic       tc;
  logic       err;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;
  logic [2:0] expected;

  int n_vec = 0;
  int n_err = 0;

  count_seq_checker dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_count     (count),
    .i_clr_err   (clr_err),
    .o_locked    (locked),
    .o_tc        (tc),
    .o_err       (err),
    .o_err_sticky(err_sticky),
    .o_err_cnt   (err_cnt),
    .o_wrap_cnt  (wrap_cnt),
    .o_expected  (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let the edge happen and settle.
  task automatic cyc(input logic a_rst, input logic a_en, input logic a_clr,
                     input logic [2:0] a_cnt);
    rst     = a_rst;
    en      = a_en;
    clr_err = a_clr;
    count   = a_cnt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] pk(input logic l, input logic t, input logic e,
                                     input logic s, input logic [7:0] ec,
                                     input logic [7:0] wc, input logic [2:0] ex);
    return {l, t, e, s, ec, wc, ex};
  endfunction

  // Compare all outputs as {locked,tc,err,sticky,err_cnt,wrap_cnt,expected}.
  task automatic chk(input string tag, input logic [22:0] req);
    logic [22:0] obs;
    obs = {locked, tc, err, err_sticky, err_cnt, wrap_cnt, expected};
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed l=%b tc=%b e=%b s=%b ecnt=%0d wcnt=%0d exp=%0d, required l=%b tc=%b e=%b s=%b ecnt=%0d wcnt=%0d exp=%0d",
             tag, obs[22], obs[21], obs[20], obs[19], obs[18:11], obs[10:3], obs[2:0],
             req[22], req[21], req[20], req[19], req[18:11], req[10:3], req[2:0]);
    end
  endtask

  initial begin
    logic [2:0] p;
    logic [2:0] pn;
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; count = 3'd0;

    // Reset
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset", pk(0, 0, 0, 0, 0, 0, 0));

    // Acquire and lock on 0,1,2,3,4
    cyc(0, 1, 0, 0);
    chk("idle_to_acq", pk(0, 0, 0, 0, 0, 0, 1));
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 0, 3);
    chk("acq_run3", pk(0, 0, 0, 0, 0, 0, 4));
    cyc(0, 1, 0, 4);
    chk("lock_after_4", pk(1, 0, 0, 0, 0, 0, 5));

    // Wrap 7 -> 0 gives a single tc pulse
    cyc(0, 1, 0, 5);
    cyc(0, 1, 0, 6);
    cyc(0, 1, 0, 7);
    chk("lock_prev7", pk(1, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0);
    chk("tc_on_wrap", pk(1, 1, 0, 0, 0, 1, 1));
    cyc(0, 1, 0, 1);
    chk("tc_one_shot", pk(1, 0, 0, 0, 0, 1, 2));

    // Drop en for one clock mid-lock
    cyc(0, 0, 0, 2);
    chk("en_drop", pk(0, 0, 0, 0, 0, 1, 0));
    cyc(0, 1, 0, 2);
    chk("reacq_start", pk(0, 0, 0, 0, 0, 1, 3));
    cyc(0, 1, 0, 3);
    cyc(0, 1, 0, 4);
    cyc(0, 1, 0, 5);
    chk("reacq_run3", pk(0, 0, 0, 0, 0, 1, 6));
    cyc(0, 1, 0, 6);
    chk("relock", pk(1, 0, 0, 0, 0, 1, 7));
    cyc(0, 1, 0, 7);
    cyc(0, 1, 0, 0);
    chk("tc_second", pk(1, 1, 0, 0, 0, 2, 1));

    // Sequence fault: prev=0, then 3 (bad), 5 (bad)
    cyc(0, 1, 0, 3);
`ifdef COUNT_SEQ_CHK_RESYNC_EN
    chk("fault_detect", pk(0, 0, 1, 1, 1, 2, 4));
    cyc(0, 1, 0, 5);
    chk("acq_bad_no_err", pk(0, 0, 0, 1, 1, 2, 6));
    cyc(0, 1, 0, 6);
    cyc(0, 1, 0, 7);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("resync_relock", pk(1, 0, 0, 1, 1, 2, 2));

    // Saturate the fault counter: a held count is a fault, then 4 good steps relock
    p = 3'd1;
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 0, p);
      for (int k = 0; k < 4; k++) begin
        p = p + 3'd1;
        cyc(0, 1, 0, p);
      end
    end
    pn = p + 3'd1;
    chk("err_cnt_sat", pk(1, 0, 0, 1, 8'd255, 2, pn));

    // Clear and fault in the same cycle
    cyc(0, 1, 1, p);
    chk("clr_and_fault", pk(0, 0, 1, 1, 1, 2, pn));
    for (int k = 0; k < 4; k++) begin
      p = p + 3'd1;
      cyc(0, 1, 0, p);
    end
    pn = p + 3'd1;
    chk("lock_before_rst", pk(1, 0, 0, 1, 1, 2, pn));
`else
    chk("fault_detect", pk(0, 0, 1, 1, 1, 2, 0));
    cyc(0, 1, 0, 5);
    chk("fault_held", pk(0, 0, 0, 1, 1, 2, 0));
    cyc(0, 1, 0, 6);
    cyc(0, 1, 0, 7);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    chk("fault_ignores_good", pk(0, 0, 0, 1, 1, 2, 0));
    cyc(0, 0, 0, 2);
    chk("fault_ignores_en", pk(0, 0, 0, 1, 1, 2, 0));
    cyc(0, 0, 1, 2);
    chk("clr_exits_fault", pk(0, 0, 0, 0, 0, 2, 0));

    // Relock, then clear and fault in the same cycle
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 0, 3);
    cyc(0, 1, 0, 4);
    chk("relock_after_clr", pk(1, 0, 0, 0, 0, 2, 5));
    cyc(0, 1, 1, 0);
    chk("clr_and_fault", pk(0, 0, 1, 1, 1, 2, 0));

    // Leave FAULT and relock for the reset test
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 2);
    cyc(0, 1, 0, 3);
    cyc(0, 1, 0, 4);
    chk("lock_before_rst", pk(1, 0, 0, 0, 0, 2, 5));
`endif

    // Reset dominates en, clr_err and a faulty count
    cyc(1, 1, 1, 2);
    chk("rst_dominates", pk(0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 5);
    chk("post_rst_idle", pk(0, 0, 0, 0, 0, 0, 6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
